// File: rtl/inst_queue_pkg.sv
// Shared types and constants for the instruction queue between fetch and if_id.
package inst_queue_pkg;

  localparam int unsigned INST_W = 32;
  localparam int unsigned ADDR_W = 32;

  typedef logic [INST_W-1:0] InstBus;
  typedef logic [ADDR_W-1:0] InstAddrBus;

  localparam InstBus     ZeroWord    = 32'h0000_0000;
  localparam logic       DualIssue   = 1'b1;
  localparam logic       SingleIssue = 1'b0;
  localparam logic       RstEnable   = 1'b1;
  localparam logic       Flush       = 1'b1;
  localparam InstAddrBus PcStep      = 32'd4;

  // One queue slot: the instruction and the PC it was fetched from.
  typedef struct packed {
    InstAddrBus pc;
    InstBus     inst;
  } iq_entry_t;

endpackage

// File: rtl/inst_queue.sv
// Circular instruction buffer: up to two pushes from fetch and up to two
// pops by decode per cycle; cleared by flush or reset.
module inst_queue
  import inst_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        wr_valid1_i,
  input  logic        wr_valid2_i,
  input  logic [31:0] wr_pc_i,
  input  logic [31:0] wr_inst1_i,
  input  logic [31:0] wr_inst2_i,
  input  logic        rd_en_i,
  input  logic        issue_i,
  output logic [31:0] pc_o,
  output logic [31:0] inst1_o,
  output logic [31:0] inst2_o,
  output logic        inst1_valid_o,
  output logic        inst2_valid_o,
  output logic        full_o,
  output logic        empty_o
);

  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic [AW:0]   count_next;
  logic [1:0]    wr_n;
  logic [1:0]    rd_n;
  logic [1:0]    rd_want;
  logic [AW-1:0] rd_ptr_nx1;
  logic [AW-1:0] wr_ptr_nx1;

  iq_entry_t mem [DEPTH];

  assign rd_ptr_nx1 = rd_ptr + AW'(1);
  assign wr_ptr_nx1 = wr_ptr + AW'(1);

  // Full means fewer than two free slots, judged on the pre-update count.
  assign full_o  = (count > (AW+1)'(DEPTH - 2));
  assign empty_o = (count == '0);

  // Accepted write and read counts for this cycle.
  always_comb begin
    wr_n       = 2'd0;
    rd_n       = 2'd0;
    rd_want    = (issue_i == DualIssue) ? 2'd2 : 2'd1;
    count_next = count;
    if (wr_valid1_i && !full_o) begin
      wr_n = wr_valid2_i ? 2'd2 : 2'd1;
    end
    if (rd_en_i) begin
      rd_n = (count >= (AW+1)'(rd_want)) ? rd_want : count[1:0];
    end
    count_next = count + (AW+1)'(wr_n) - (AW+1)'(rd_n);
  end

  // Pointer and occupancy state; rst outranks flush, which outranks traffic.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush == Flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= rd_ptr + AW'(rd_n);
      wr_ptr <= wr_ptr + AW'(wr_n);
      count  <= count_next;
    end
  end

  // Storage is not reset; slots beyond count are masked on the outputs.
  always_ff @(posedge clk) begin
    if (rst != RstEnable && flush != Flush) begin
      if (wr_n != 2'd0) begin
        mem[wr_ptr] <= '{pc: wr_pc_i, inst: wr_inst1_i};
      end
      if (wr_n == 2'd2) begin
        mem[wr_ptr_nx1] <= '{pc: wr_pc_i + PcStep, inst: wr_inst2_i};
      end
    end
  end

  assign inst1_valid_o = (count >= (AW+1)'(1));
  assign inst2_valid_o = (count >= (AW+1)'(2));
  assign pc_o          = inst1_valid_o ? mem[rd_ptr].pc       : ZeroWord;
  assign inst1_o       = inst1_valid_o ? mem[rd_ptr].inst     : ZeroWord;
  assign inst2_o       = inst2_valid_o ? mem[rd_ptr_nx1].inst : ZeroWord;

endmodule

// File: tb/tb_inst_queue.sv
// Bench for inst_queue: queue-based reference model compared every cycle,
// plus hand-computed literal expectations on directed scenarios.
module tb_inst_queue;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        wr_valid1_i = 1'b0;
  logic        wr_valid2_i = 1'b0;
  logic [31:0] wr_pc_i = '0;
  logic [31:0] wr_inst1_i = '0;
  logic [31:0] wr_inst2_i = '0;
  logic        rd_en_i = 1'b0;
  logic        issue_i = 1'b0;
  logic [31:0] pc_o, inst1_o, inst2_o;
  logic        inst1_valid_o, inst2_valid_o, full_o, empty_o;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  // Model contents: {pc, inst}, oldest at index 0.
  logic [63:0] mq[$];

  inst_queue #(.DEPTH(16), .AW(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .wr_valid1_i(wr_valid1_i), .wr_valid2_i(wr_valid2_i),
    .wr_pc_i(wr_pc_i), .wr_inst1_i(wr_inst1_i), .wr_inst2_i(wr_inst2_i),
    .rd_en_i(rd_en_i), .issue_i(issue_i),
    .pc_o(pc_o), .inst1_o(inst1_o), .inst2_o(inst2_o),
    .inst1_valid_o(inst1_valid_o), .inst2_valid_o(inst2_valid_o),
    .full_o(full_o), .empty_o(empty_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference behaviour: pops from the front, pushes to the back.
  always @(posedge clk) begin
    if (rst || flush) begin
      mq.delete();
    end else begin
      int sz;
      int want;
      int rd_n;
      bit full;
      sz   = mq.size();
      full = (sz >= DEPTH - 1);
      want = issue_i ? 2 : 1;
      rd_n = rd_en_i ? ((want < sz) ? want : sz) : 0;
      for (int k = 0; k < rd_n; k++) void'(mq.pop_front());
      if (wr_valid1_i && !full) begin
        mq.push_back({wr_pc_i, wr_inst1_i});
        if (wr_valid2_i) mq.push_back({wr_pc_i + 32'd4, wr_inst2_i});
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (check_en) begin
      int sz;
      logic [63:0] e0, e1;
      sz = mq.size();
      e0 = (sz >= 1) ? mq[0] : 64'd0;
      e1 = (sz >= 2) ? mq[1] : 64'd0;
      check("pc_o",          pc_o,                  e0[63:32]);
      check("inst1_o",       inst1_o,               e0[31:0]);
      check("inst2_o",       inst2_o,               e1[31:0]);
      check("inst1_valid_o", 32'(inst1_valid_o),    32'(sz >= 1));
      check("inst2_valid_o", 32'(inst2_valid_o),    32'(sz >= 2));
      check("full_o",        32'(full_o),           32'(sz > DEPTH - 2));
      check("empty_o",       32'(empty_o),          32'(sz == 0));
    end
  end

  task automatic drive(input logic r, input logic f, input logic v1, input logic v2,
                       input logic [31:0] pc, input logic [31:0] i1, input logic [31:0] i2,
                       input logic re, input logic iss);
    rst = r; flush = f; wr_valid1_i = v1; wr_valid2_i = v2;
    wr_pc_i = pc; wr_inst1_i = i1; wr_inst2_i = i2;
    rd_en_i = re; issue_i = iss;
    @(negedge clk);
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0);
  endtask

  initial begin
    drive(1, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0);
    drive(1, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0);
    check_en = 1'b1;
    check("rst_empty", 32'(empty_o), 32'd1);
    check("rst_pc", pc_o, 32'h0);
    check("rst_full", 32'(full_o), 32'd0);

    // Basic dual write then dual read.
    drive(0, 0, 1, 1, 32'hBFC0_0000, 32'h2401_0001, 32'h2402_0002, 0, 0);
    check("t1_pc", pc_o, 32'hBFC0_0000);
    check("t1_inst1", inst1_o, 32'h2401_0001);
    check("t1_inst2", inst2_o, 32'h2402_0002);
    check("t1_v2", 32'(inst2_valid_o), 32'd1);
    drive(0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 1, 1);
    check("t1_empty", 32'(empty_o), 32'd1);

    // Fill with eight dual writes; full appears only once two slots are not free.
    for (int i = 0; i < 8; i++) begin
      drive(0, 0, 1, 1, 32'h1000 + 32'(8 * i), 32'hA000 + 32'(2 * i), 32'hA001 + 32'(2 * i), 0, 0);
      if (i == 6) check("t2_not_full_14", 32'(full_o), 32'd0);
    end
    check("t2_full_16", 32'(full_o), 32'd1);
    drive(0, 0, 1, 1, 32'hDEAD_0000, 32'hDEAD_0001, 32'hDEAD_0002, 0, 0);
    check("t2_head_kept", pc_o, 32'h1000);
    drive(0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 1, 0);
    check("t2_pop1_pc", pc_o, 32'h1004);
    check("t2_full_15", 32'(full_o), 32'd1);
    drive(0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 1, 0);
    check("t2_full_14", 32'(full_o), 32'd0);
    for (int i = 0; i < 7; i++) drive(0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 1, 1);
    check("t2_drained", 32'(empty_o), 32'd1);

    // Dual read with a single entry pops only one.
    drive(0, 0, 1, 0, 32'h0000_0040, 32'h1111_1111, 32'h2222_2222, 0, 0);
    check("t3_v2", 32'(inst2_valid_o), 32'd0);
    check("t3_inst2", inst2_o, 32'h0);
    drive(0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 1, 1);
    check("t3_empty", 32'(empty_o), 32'd1);

    // Walk both pointers to slot 15, then write a pair that wraps to slot 0.
    drive(0, 0, 1, 0, 32'h100, 32'h5000, 32'h0, 1, 0);
    for (int i = 0; i < 11; i++)
      drive(0, 0, 1, 0, 32'h104 + 32'(4 * i), 32'h5001 + 32'(i), 32'h0, 1, 0);
    drive(0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 1, 0);
    check("t4_pre_empty", 32'(empty_o), 32'd1);
    drive(0, 0, 1, 1, 32'h8000_0100, 32'hCAFE_0001, 32'hCAFE_0002, 0, 0);
    check("t4_pc", pc_o, 32'h8000_0100);
    check("t4_inst1", inst1_o, 32'hCAFE_0001);
    check("t4_inst2_wrap", inst2_o, 32'hCAFE_0002);
    drive(0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 1, 0);
    check("t4_pc_slot0", pc_o, 32'h8000_0104);
    drive(0, 0, 1, 0, 32'h300, 32'h3333, 32'h0, 1, 0);
    check("t4_after_wrap", pc_o, 32'h300);

    // Reach six entries, then flush while writing and reading.
    drive(0, 0, 1, 1, 32'h400, 32'h4400, 32'h4404, 0, 0);
    drive(0, 0, 1, 1, 32'h408, 32'h4408, 32'h440C, 0, 0);
    drive(0, 0, 1, 0, 32'h410, 32'h4410, 32'h0, 0, 0);
    check("t5_v2_pre", 32'(inst2_valid_o), 32'd1);
    drive(0, 1, 1, 1, 32'h500, 32'h5500, 32'h5504, 1, 1);
    check("t5_flush_empty", 32'(empty_o), 32'd1);
    check("t5_flush_v1", 32'(inst1_valid_o), 32'd0);
    drive(0, 0, 1, 0, 32'h2000, 32'h7777, 32'h0, 0, 0);
    check("t5_post_flush_pc", pc_o, 32'h2000);
    drive(1, 0, 1, 1, 32'h600, 32'h6600, 32'h6604, 0, 0);
    check("t5_rst_empty", 32'(empty_o), 32'd1);
    drive(0, 0, 1, 0, 32'h2100, 32'h8888, 32'h0, 0, 0);
    check("t5_post_rst_inst", inst1_o, 32'h8888);

    // Random traffic with alternating write-heavy and read-heavy phases.
    for (int c = 0; c < 10000; c++) begin
      logic v1, v2, re, iss, fl;
      bit heavy_rd;
      heavy_rd = ((c / 500) % 2) == 1;
      v1  = heavy_rd ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      v2  = v1 & 1'($urandom_range(0, 1));
      re  = heavy_rd ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      iss = 1'($urandom_range(0, 1));
      fl  = ($urandom_range(0, 399) == 0);
      drive(0, fl, v1, v2, $urandom() & 32'hFFFF_FFFC, $urandom(), $urandom(), re, iss);
    end
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_queue.md
# inst_queue

Circular instruction buffer between the I-cache fetch stage and `if_id`. Accepts up to two sequential instructions per cycle from fetch and presents the two oldest to `if_id` as `inst1`/`inst2` with their PC. It pops one or two entries per cycle according to the decoder's issue decision. Its occupancy drives the fetch stall request, and it is cleared on any pipeline flush.

## Interface
Parameters:
- DEPTH, 16: number of entries; power of two, ≥4.
- AW, 4: pointer width, log2(DEPTH).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  clears the queue (exception or failed branch prediction).
- wr_valid1_i  in  1  fetch word 1 valid.
- wr_valid2_i  in  1  fetch word 2 valid; legal only when wr_valid1_i=1.
- wr_pc_i  in  32  PC of word 1; word 2 PC = wr_pc_i+4.
- wr_inst1_i  in  32  instruction word 1.
- wr_inst2_i  in  32  instruction word 2.
- rd_en_i  in  1  decode consumes this cycle (0 while stall[1] = Stop).
- issue_i  in  1  DualIssue(1) pops two, SingleIssue(0) pops one.
- pc_o  out  32  PC of head entry.
- inst1_o  out  32  head instruction.
- inst2_o  out  32  head+1 instruction.
- inst1_valid_o  out  1  head entry present.
- inst2_valid_o  out  1  head+1 entry present.
- full_o  out  1  fewer than 2 free slots; fetch stall request.
- empty_o  out  1  count = 0.

## Operation
- Storage: DEPTH entries of {pc[31:0], inst[31:0]}; rd_ptr, wr_ptr of AW bits wrap modulo DEPTH; count of AW+1 bits.
- Write count: wr_n = wr_valid1_i + (wr_valid1_i & wr_valid2_i). Entries go to wr_ptr and wr_ptr+1, with PCs wr_pc_i and wr_pc_i+4.
- Writes are ignored while full_o=1; fetch must hold the data and retry. wr_valid2_i without wr_valid1_i is ignored.
- Read count: when rd_en_i=0, rd_n=0. Otherwise rd_n = min(issue_i ? 2 : 1, count).
- Update: count_next = count + wr_n - rd_n; rd_ptr += rd_n; wr_ptr += wr_n.
- A simultaneous read and write is legal at any occupancy, including when full. The full test uses the pre-update count.
- Outputs are combinational from the registered array and pointers:
  - pc_o = pc[rd_ptr]; inst1_o = inst[rd_ptr]; inst2_o = inst[rd_ptr+1].
  - inst1_valid_o = (count≥1); inst2_valid_o = (count≥2).
  - Invalid slots drive ZeroWord on inst and pc.
- full_o = (count > DEPTH-2); empty_o = (count == 0).
- flush has priority over read and write: count, rd_ptr and wr_ptr go to 0, and same-cycle write data is discarded.
- Sequential PC continuity across entries is not checked; each entry carries its own PC.

## Timing
- Reset: all pointers and count are 0. Outputs become pc_o=0, inst1_o=inst2_o=0, inst1_valid_o=inst2_valid_o=0, full_o=0, empty_o=1.
- Reset mid-operation discards contents exactly as flush does. rst outranks flush.
- Write-to-output latency is 1 cycle; a write into an empty queue is not bypassed.
- The pop takes effect at the edge; new head data is visible in the next cycle.
- flush asserted in cycle N gives empty_o=1 in cycle N+1. A fetch write in N+1 is accepted normally.
- Wrap-around: writing 2 entries at wr_ptr=DEPTH-1 fills slots DEPTH-1 and 0. inst2_o at rd_ptr=DEPTH-1 reads slot 0.

## Structure
- Shared defines file holds `ZeroWord`, `InstBus`, `InstAddrBus`, `DualIssue`, `SingleIssue`, `RstEnable` and `Flush`. Do not redefine them locally.
- Single module with no sub-module. The storage is a register array inside inst_queue. Pointer/count arithmetic is at most ~40 lines.

## Test plan
- Reset, then write pc 0xBFC00000 with 0x24010001/0x24020002 → next cycle pc_o=0xBFC00000, both valid, count 2; rd_en_i=1 with DualIssue → empty_o=1 the following cycle.
- Fill with 8 dual writes (16 entries) → full_o rises at count 15. A write attempted while full leaves count unchanged, and the head stays the first PC.
- count=1, rd_en_i=1 with DualIssue → only 1 popped; inst2_valid_o was 0 and inst2_o=0.
- rd_ptr=wr_ptr=15, write pc 0x80000100 pair, then dual read → inst1_o from slot 15, inst2_o from slot 0 with pc 0x80000104 stored; both pointers end at 1.
- count=6 with flush=1, wr_valid1_i=1 and rd_en_i=1 in the same cycle → next cycle count 0, empty_o=1, pointers 0, write discarded.
- Random mix of 1/2-word writes and single/dual reads over 10k cycles → instruction/PC order matches a scoreboard FIFO; count never exceeds DEPTH.
